// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: shared opcodes, ALU control codes and MDU/FSM enums
package alu_ctrl_pkg;
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_OR    = 2'b10;
  localparam logic [1:0] ALUOP_FUNCT = 2'b11;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_XOR   = 6'b100110;
  localparam logic [5:0] FN_NOR   = 6'b100111;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;
  localparam logic [3:0] CTRL_AND  = 4'b0000;
  localparam logic [3:0] CTRL_OR   = 4'b0001;
  localparam logic [3:0] CTRL_ADD  = 4'b0010;
  localparam logic [3:0] CTRL_XOR  = 4'b0011;
  localparam logic [3:0] CTRL_SUB  = 4'b0110;
  localparam logic [3:0] CTRL_SLT  = 4'b0111;
  localparam logic [3:0] CTRL_PASS = 4'b1000;
  localparam logic [3:0] CTRL_NOR  = 4'b1100;
  localparam logic [3:0] CTRL_ILL  = 4'b1111;
  typedef enum logic [1:0] {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU} mdu_op_e;
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;
endpackage

// File: rtl/mdu_iter.sv
// mdu_iter: radix-2 shift-add multiply / restoring divide on unsigned magnitudes
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             step,
  input  logic             div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi_nxt,
  output logic [WIDTH-1:0] lo_nxt,
  output logic             last
);
  localparam int CW = $clog2(WIDTH + 1);
  logic [WIDTH-1:0] hi, lo, m, diff;
  logic [WIDTH:0] sum, sh;
  logic [CW-1:0] cnt;
  logic div_q, ge;
  // multiply: lo holds the multiplier, m the multiplicand; divide: lo holds the dividend, m the divisor
  always_ff @(posedge clk) begin
    if (rst) begin
      {hi, lo, m, cnt, div_q} <= '0;
    end else if (start) begin
      hi <= '0;
      lo <= div ? a : b;
      m <= div ? b : a;
      div_q <= div;
      cnt <= CW'(WIDTH);
    end else if (step) begin
      hi <= hi_nxt;
      lo <= lo_nxt;
      cnt <= cnt - CW'(1);
    end
  end
  always_comb begin
    sum = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
    sh = {hi, lo[WIDTH-1]};
    ge = sh >= {1'b0, m};
    diff = sh[WIDTH-1:0] - m;
    hi_nxt = div_q ? (ge ? diff : sh[WIDTH-1:0]) : sum[WIDTH:1];
    lo_nxt = div_q ? {lo[WIDTH-2:0], ge} : {sum[0], lo[WIDTH-1:1]};
  end
  assign last = cnt == CW'(1);
endmodule

// File: rtl/alu_ctrl_mdu.sv
// alu_ctrl_mdu: EX-stage ALU control decoder with an iterative multiply/divide unit
module alu_ctrl_mdu
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ENABLE_DIV = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic [1:0]       ALUOp_i,
  input  logic [5:0]       funct_i,
  input  logic [WIDTH-1:0] rs_data_i,
  input  logic [WIDTH-1:0] rt_data_i,
  output logic [3:0]       ALUCtrl_o,
  output logic             illegal_o,
  output logic             stall_o,
  output logic             mdu_done_o,
  output logic [WIDTH-1:0] mdu_hi_o,
  output logic [WIDTH-1:0] mdu_lo_o
);
  state_e state, state_n;
  mdu_op_e op;
  logic [3:0] fn_ctrl;
  logic mdu_fn, div_fn, signed_fn, mdu_ok, launch, start, step, last, finish;
  logic a_neg, b_neg, op_div, res_neg, rem_neg;
  logic [WIDTH-1:0] a_mag, b_mag, hi_nxt, lo_nxt, hi_fix, lo_fix;
  logic [2*WIDTH-1:0] prod_fix;
  assign mdu_fn = funct_i inside {FN_MULT, FN_MULTU, FN_DIV, FN_DIVU};
  assign div_fn = funct_i == FN_DIV || funct_i == FN_DIVU;
  assign signed_fn = funct_i == FN_MULT || funct_i == FN_DIV;
  assign mdu_ok = mdu_fn && (ENABLE_DIV != 0 || !div_fn);
  always_comb begin
    case (funct_i)
      FN_ADD:  fn_ctrl = CTRL_ADD;
      FN_SUB:  fn_ctrl = CTRL_SUB;
      FN_AND:  fn_ctrl = CTRL_AND;
      FN_OR:   fn_ctrl = CTRL_OR;
      FN_XOR:  fn_ctrl = CTRL_XOR;
      FN_NOR:  fn_ctrl = CTRL_NOR;
      FN_SLT:  fn_ctrl = CTRL_SLT;
      default: fn_ctrl = mdu_ok ? CTRL_PASS : CTRL_ILL;
    endcase
  end
  assign ALUCtrl_o = ALUOp_i == ALUOP_ADD ? CTRL_ADD :
                     ALUOp_i == ALUOP_SUB ? CTRL_SUB :
                     ALUOp_i == ALUOP_OR  ? CTRL_OR  : fn_ctrl;
  assign illegal_o = ALUOp_i == ALUOP_FUNCT && fn_ctrl == CTRL_ILL;
  // only IDLE can launch, so the still-valid stalled instruction is ignored in DONE
  assign launch = valid_i && ALUOp_i == ALUOP_FUNCT && mdu_ok && !rst_i && state == S_IDLE;
  assign a_neg = signed_fn && rs_data_i[WIDTH-1];
  assign b_neg = signed_fn && rt_data_i[WIDTH-1];
  assign a_mag = a_neg ? -rs_data_i : rs_data_i;
  assign b_mag = b_neg ? -rt_data_i : rt_data_i;
  always_ff @(posedge clk_i) state <= rst_i ? S_IDLE : state_n;
  always_comb begin
    state_n = state == S_IDLE ? (launch ? S_BUSY : S_IDLE) :
              state == S_BUSY ? (last ? S_DONE : S_BUSY) : S_IDLE;
  end
  always_comb begin
    start = launch;
    step = state == S_BUSY;
    stall_o = launch || step;
    mdu_done_o = state == S_DONE;
  end
  // a zero divisor keeps the quotient positive so LO stays all ones and HI restores the dividend
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      {res_neg, rem_neg} <= '0;
      op <= OP_MULT;
    end else if (launch) begin
      op <= div_fn ? (signed_fn ? OP_DIV : OP_DIVU) : (signed_fn ? OP_MULT : OP_MULTU);
      res_neg <= (a_neg ^ b_neg) && rt_data_i != '0;
      rem_neg <= a_neg;
    end
  end
  assign op_div = op == OP_DIV || op == OP_DIVU;
  assign finish = state == S_BUSY && last;
  always_comb begin
    prod_fix = res_neg ? -{hi_nxt, lo_nxt} : {hi_nxt, lo_nxt};
    hi_fix = op_div ? (rem_neg ? -hi_nxt : hi_nxt) : prod_fix[2*WIDTH-1:WIDTH];
    lo_fix = op_div ? (res_neg ? -lo_nxt : lo_nxt) : prod_fix[WIDTH-1:0];
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) {mdu_hi_o, mdu_lo_o} <= '0;
    else if (finish) {mdu_hi_o, mdu_lo_o} <= {hi_fix, lo_fix};
  end
  mdu_iter #(.WIDTH(WIDTH)) u_iter (
    .clk(clk_i),
    .rst(rst_i),
    .start(start),
    .step(step),
    .div(div_fn),
    .a(a_mag),
    .b(b_mag),
    .hi_nxt(hi_nxt),
    .lo_nxt(lo_nxt),
    .last(last)
  );
endmodule

// File: tb/tb_alu_ctrl_mdu.sv
// tb_alu_ctrl_mdu: random and directed checks of decode and MDU against an arithmetic model
module tb_alu_ctrl_mdu;
  logic clk_i = 0, rst_i = 1, valid_i = 0, valid2 = 0;
  logic [1:0] ALUOp_i = 0;
  logic [5:0] funct_i = 0;
  logic [31:0] rs_data_i = 0, rt_data_i = 0;
  logic [3:0] ALUCtrl_o, ctrl2;
  logic illegal_o, stall_o, mdu_done_o, illegal2, stall2, done2;
  logic [31:0] mdu_hi_o, mdu_lo_o, hi2, lo2;
  int checks = 0, failures = 0;

  alu_ctrl_mdu dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ALUOp_i(ALUOp_i), .funct_i(funct_i),
    .rs_data_i(rs_data_i), .rt_data_i(rt_data_i), .ALUCtrl_o(ALUCtrl_o), .illegal_o(illegal_o),
    .stall_o(stall_o), .mdu_done_o(mdu_done_o), .mdu_hi_o(mdu_hi_o), .mdu_lo_o(mdu_lo_o)
  );
  alu_ctrl_mdu #(.ENABLE_DIV(0)) dut_nodiv (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid2), .ALUOp_i(ALUOp_i), .funct_i(funct_i),
    .rs_data_i(rs_data_i), .rt_data_i(rt_data_i), .ALUCtrl_o(ctrl2), .illegal_o(illegal2),
    .stall_o(stall2), .mdu_done_o(done2), .mdu_hi_o(hi2), .mdu_lo_o(lo2)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] ref_dec(input logic [1:0] op, input logic [5:0] fn, input bit en_div);
    if (op == 2'b00) return 5'b0_0010;
    if (op == 2'b01) return 5'b0_0110;
    if (op == 2'b10) return 5'b0_0001;
    case (fn)
      6'h20: return 5'b0_0010;
      6'h22: return 5'b0_0110;
      6'h24: return 5'b0_0000;
      6'h25: return 5'b0_0001;
      6'h26: return 5'b0_0011;
      6'h27: return 5'b0_1100;
      6'h2a: return 5'b0_0111;
      6'h18, 6'h19: return 5'b0_1000;
      6'h1a, 6'h1b: return en_div ? 5'b0_1000 : 5'b1_1111;
      default: return 5'b1_1111;
    endcase
  endfunction

  // returns {HI, LO}
  function automatic logic [63:0] ref_mdu(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (fn)
      6'h18: return 64'(sa * sb);
      6'h19: return ua * ub;
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (fn == 6'h1a) begin
          q = sa / sb;
          r = sa % sb;
        end else begin
          q = longint'(ua / ub);
          r = longint'(ua % ub);
        end
        return {r[31:0], q[31:0]};
      end
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'(int'($urandom_range(0, 20)) - 10);
      default: return $urandom;
    endcase
  endfunction

  task automatic do_op(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b, input bit hold);
    int n;
    bit got;
    logic [63:0] exp;
    n = 0;
    got = 0;
    exp = ref_mdu(fn, a, b);
    @(negedge clk_i);
    valid_i = 1;
    ALUOp_i = 2'b11;
    funct_i = fn;
    rs_data_i = a;
    rt_data_i = b;
    for (int c = 0; c < 45; c++) begin
      #1;
      if (mdu_done_o) begin
        got = 1;
        break;
      end
      if (stall_o) n++;
      @(negedge clk_i);
      if (!hold) begin
        valid_i = 1'($urandom);
        rs_data_i = $urandom;
        rt_data_i = $urandom;
      end
    end
    chk("stall_len", 64'(n), 64'd33);
    chk("done_seen", 64'(got), 64'd1);
    chk("stall_at_done", 64'(stall_o), 64'd0);
    chk("hilo", {mdu_hi_o, mdu_lo_o}, exp);
  endtask

  initial begin
    int pulses;
    repeat (2) @(negedge clk_i);
    #1;
    chk("rst_hilo", {mdu_hi_o, mdu_lo_o}, 64'd0);
    chk("rst_done", 64'(mdu_done_o), 64'd0);
    chk("rst_stall", 64'(stall_o), 64'd0);
    @(negedge clk_i);
    rst_i = 0;
    for (int op = 0; op < 4; op++)
      for (int f = 0; f < 64; f++) begin
        ALUOp_i = 2'(op);
        funct_i = 6'(f);
        #1;
        chk("dec", {illegal_o, ALUCtrl_o}, 64'(ref_dec(2'(op), 6'(f), 1)));
        chk("dec_nodiv", {illegal2, ctrl2}, 64'(ref_dec(2'(op), 6'(f), 0)));
      end
    do_op(6'h18, 32'hFFFF_FFFD, 32'd7, 1);
    do_op(6'h19, 32'hFFFF_FFFF, 32'd2, 1);
    do_op(6'h1a, 32'hFFFF_FFF9, 32'd2, 0);
    do_op(6'h1b, 32'd7, 32'd0, 0);
    do_op(6'h1a, 32'h8000_0000, 32'hFFFF_FFFF, 1);
    do_op(6'h1a, 32'hFFFF_FFF9, 32'd0, 0);
    @(negedge clk_i);
    valid_i = 0;
    #1;
    chk("single_pulse", 64'(mdu_done_o), 64'd0);
    chk("hold_hi", 64'(mdu_hi_o), 64'hFFFF_FFF9);
    for (int i = 0; i < 25; i++)
      do_op(6'h18 + 6'($urandom_range(0, 3)), pick(), pick(), 1'($urandom));
    @(negedge clk_i);
    valid_i = 1;
    ALUOp_i = 2'b11;
    funct_i = 6'h18;
    rs_data_i = 32'h1234_5678;
    rt_data_i = 32'h9ABC_DEF1;
    @(negedge clk_i);
    valid_i = 0;
    repeat (9) @(negedge clk_i);
    rst_i = 1;
    @(negedge clk_i);
    rst_i = 0;
    #1;
    chk("midrst_stall", 64'(stall_o), 64'd0);
    chk("midrst_hilo", {mdu_hi_o, mdu_lo_o}, 64'd0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (mdu_done_o) pulses++;
      @(negedge clk_i);
      #1;
    end
    chk("midrst_no_done", 64'(pulses), 64'd0);
    do_op(6'h19, 32'hDEAD_BEEF, 32'h0000_1001, 0);
    @(negedge clk_i);
    valid_i = 0;
    valid2 = 1;
    ALUOp_i = 2'b11;
    funct_i = 6'h1a;
    #1;
    chk("nodiv_illegal", {illegal2, ctrl2}, 64'h1F);
    chk("nodiv_stall", 64'(stall2), 64'd0);
    @(negedge clk_i);
    #1;
    chk("nodiv_idle", {stall2, done2}, 64'd0);
    valid2 = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
